vp_recovery_ctrl: RTL and testbench

Recovery controller directly downstream of the memory-stage value predictor. It tracks the speculative window opened by a load value prediction and caps how many instructions may issue under it. On a misprediction it flushes the pipeline, redirects fetch to the instruction after the mispredicted load, and then completes the `recovery_done` / `recovery_done_ack` handshake back to the predictor. It also keeps saturating statistics for correct and recovered predictions.

---
 rtl/vp_recovery_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_vp_recovery_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// vp_recovery_ctrl
//
// Recovery controller that sits directly behind the memory-stage value
// predictor. While a load value prediction is outstanding it tracks the
// speculative window and limits how many instructions may issue under it.
// On a misprediction it flushes the pipeline, redirects fetch to the
// instruction after the mispredicted load, and then completes the
// recovery_done / recovery_done_ack handshake with the predictor.
// Saturating counters record correct predictions and started recoveries.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   vp_lock              : predictor has an outstanding prediction
//   en_recover           : misprediction detected (level)
//   vp_done              : prediction verified correct (level)
//   last_predicted_pc    : PC of the predicted load
//   issue_valid          : one instruction issued this cycle
//   redirect_ready       : fetch accepts the redirect
//   recovery_done_ack    : predictor acknowledges recovery completion
//   flush                : kill younger in-flight instructions
//   stall_fetch          : hold fetch and issue
//   redirect_valid       : fetch redirect request
//   redirect_pc          : redirect target (load PC + 4)
//   recovery_done        : recovery complete, held until acknowledged
//   busy                 : controller is not idle
//   n_correct, n_recover : saturating statistics
//
// Every output is a register, so there is no combinational path from any
// input to any output.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module vp_recovery_ctrl #(
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int FLUSH_CYCLES = 3,
  parameter int MAX_SPEC     = 8,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vp_lock,
  input  logic                  en_recover,
  input  logic                  vp_done,
  input  logic [ADDR_WIDTH-1:0] last_predicted_pc,
  input  logic                  issue_valid,
  input  logic                  redirect_ready,
  input  logic                  recovery_done_ack,
  output logic                  flush,
  output logic                  stall_fetch,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  recovery_done,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] n_correct,
  output logic [STAT_WIDTH-1:0] n_recover
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPEC,
    S_FLUSH,
    S_REDIRECT,
    S_DONE
  } state_t;

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0]        FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
  localparam logic [7:0]            SPEC_MAX   = 8'(MAX_SPEC);
  localparam logic [7:0]            SPEC_PRE   = 8'(MAX_SPEC - 1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX   = '1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

  state_t                  state;
  logic                    armed;
  logic                    vp_lock_q;
  logic [7:0]              spec_cnt;
  logic [FCW-1:0]          flush_cnt;
  logic [ADDR_WIDTH-1:0]   saved_pc;

  // armed blocks a held en_recover level from starting a second recovery;
  // it is only re-armed once en_recover has been seen low.
  logic recover_go;
  logic lock_rise;

  assign recover_go = armed & en_recover;
  assign lock_rise  = vp_lock & ~vp_lock_q;

  // Single FSM with all outputs registered alongside the state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      armed          <= 1'b1;
      vp_lock_q      <= 1'b0;
      spec_cnt       <= '0;
      flush_cnt      <= '0;
      saved_pc       <= '0;
      flush          <= 1'b0;
      stall_fetch    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      recovery_done  <= 1'b0;
      busy           <= 1'b0;
      n_correct      <= '0;
      n_recover      <= '0;
    end else begin
      vp_lock_q <= vp_lock;
      if (!en_recover) begin
        armed <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (recover_go) begin
            state       <= S_FLUSH;
            saved_pc    <= last_predicted_pc;
            armed       <= 1'b0;
            flush_cnt   <= '0;
            flush       <= 1'b1;
            stall_fetch <= 1'b1;
            busy        <= 1'b1;
            if (n_recover != STAT_MAX) begin
              n_recover <= n_recover + 1'b1;
            end
          end else if (lock_rise) begin
            state    <= S_SPEC;
            saved_pc <= last_predicted_pc;
            spec_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        S_SPEC: begin
          // Misprediction wins over a same-cycle vp_done.
          if (recover_go) begin
            state       <= S_FLUSH;
            armed       <= 1'b0;
            flush_cnt   <= '0;
            spec_cnt    <= '0;
            flush       <= 1'b1;
            stall_fetch <= 1'b1;
            if (n_recover != STAT_MAX) begin
              n_recover <= n_recover + 1'b1;
            end
          end else if (vp_done) begin
            state       <= S_IDLE;
            stall_fetch <= 1'b0;
            busy        <= 1'b0;
            if (n_correct != STAT_MAX) begin
              n_correct <= n_correct + 1'b1;
            end
          end else if (!vp_lock) begin
            state       <= S_IDLE;
            stall_fetch <= 1'b0;
            busy        <= 1'b0;
          end else if (issue_valid && (spec_cnt != SPEC_MAX)) begin
            // stall_fetch rises together with the counter reaching the cap.
            spec_cnt <= spec_cnt + 1'b1;
            if (spec_cnt == SPEC_PRE) begin
              stall_fetch <= 1'b1;
            end
          end
        end

        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state          <= S_REDIRECT;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= saved_pc + PC_STEP;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        S_REDIRECT: begin
          if (redirect_ready) begin
            state          <= S_DONE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall_fetch    <= 1'b0;
            recovery_done  <= 1'b1;
          end
        end

        S_DONE: begin
          if (recovery_done_ack) begin
            state         <= S_IDLE;
            recovery_done <= 1'b0;
            busy          <= 1'b0;
          end
        end

        default: begin
          state          <= S_IDLE;
          flush          <= 1'b0;
          stall_fetch    <= 1'b0;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
          recovery_done  <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vp_recovery_ctrl
//
// Directed bench for vp_recovery_ctrl with default parameters
// (32-bit PC, 3 flush cycles, speculation cap of 8, 16-bit statistics).
// Inputs change 1 ns after a rising edge and outputs are sampled at that
// same point, so each check sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_vp_recovery_ctrl;

  logic        clk;
  logic        rst;
  logic        vp_lock;
  logic        en_recover;
  logic        vp_done;
  logic [31:0] last_predicted_pc;
  logic        issue_valid;
  logic        redirect_ready;
  logic        recovery_done_ack;
  logic        flush;
  logic        stall_fetch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        recovery_done;
  logic        busy;
  logic [15:0] n_correct;
  logic [15:0] n_recover;

  int checks;
  int failures;

  vp_recovery_ctrl #(
    .ADDR_WIDTH  (32),
    .FLUSH_CYCLES(3),
    .MAX_SPEC    (8),
    .STAT_WIDTH  (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .vp_lock          (vp_lock),
    .en_recover       (en_recover),
    .vp_done          (vp_done),
    .last_predicted_pc(last_predicted_pc),
    .issue_valid      (issue_valid),
    .redirect_ready   (redirect_ready),
    .recovery_done_ack(recovery_done_ack),
    .flush            (flush),
    .stall_fetch      (stall_fetch),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .recovery_done    (recovery_done),
    .busy             (busy),
    .n_correct        (n_correct),
    .n_recover        (n_recover)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts the check and reports any miss.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every output checked against one full expected vector.
  task automatic check_all(input string tag, input logic e_flush, input logic e_stall,
                           input logic e_rv, input logic [31:0] e_pc, input logic e_done,
                           input logic e_busy, input logic [15:0] e_nc,
                           input logic [15:0] e_nr);
    check_output({tag, ".flush"},          32'(flush),          32'(e_flush));
    check_output({tag, ".stall_fetch"},    32'(stall_fetch),    32'(e_stall));
    check_output({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e_rv));
    check_output({tag, ".redirect_pc"},    redirect_pc,         e_pc);
    check_output({tag, ".recovery_done"},  32'(recovery_done),  32'(e_done));
    check_output({tag, ".busy"},           32'(busy),           32'(e_busy));
    check_output({tag, ".n_correct"},      32'(n_correct),      32'(e_nc));
    check_output({tag, ".n_recover"},      32'(n_recover),      32'(e_nr));
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst               = 1'b1;
    vp_lock           = 1'b0;
    en_recover        = 1'b0;
    vp_done           = 1'b0;
    last_predicted_pc = 32'h0;
    issue_valid       = 1'b0;
    redirect_ready    = 1'b0;
    recovery_done_ack = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_all("reset", 0, 0, 0, 32'h0, 0, 0, 16'd0, 16'd0);
    tick();
    check_all("idle_after_reset", 0, 0, 0, 32'h0, 0, 0, 16'd0, 16'd0);

    // Correct prediction: SPEC, 3 issues, vp_done back to IDLE
    $display("[TB] correct prediction");
    last_predicted_pc = 32'h0000_2000;
    vp_lock = 1'b1;
    tick();
    check_all("spec_enter", 0, 0, 0, 32'h0, 0, 1, 16'd0, 16'd0);
    issue_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all($sformatf("spec_issue%0d", i), 0, 0, 0, 32'h0, 0, 1, 16'd0, 16'd0);
    end
    issue_valid = 1'b0;
    vp_done = 1'b1;
    tick();
    check_all("vp_done_idle", 0, 0, 0, 32'h0, 0, 0, 16'd1, 16'd0);
    vp_done = 1'b0;
    vp_lock = 1'b0;
    tick();
    check_all("idle_after_correct", 0, 0, 0, 32'h0, 0, 0, 16'd1, 16'd0);

    // Misprediction with redirect_ready tied high
    $display("[TB] misprediction defaults");
    last_predicted_pc = 32'h0000_1000;
    redirect_ready = 1'b1;
    vp_lock = 1'b1;
    tick();
    check_all("mis_spec", 0, 0, 0, 32'h0, 0, 1, 16'd1, 16'd0);
    en_recover = 1'b1;
    tick();
    check_all("mis_flush1", 1, 1, 0, 32'h0, 0, 1, 16'd1, 16'd1);
    en_recover = 1'b0;
    tick();
    check_all("mis_flush2", 1, 1, 0, 32'h0, 0, 1, 16'd1, 16'd1);
    tick();
    check_all("mis_flush3", 1, 1, 0, 32'h0, 0, 1, 16'd1, 16'd1);
    tick();
    check_all("mis_redirect", 0, 1, 1, 32'h0000_1004, 0, 1, 16'd1, 16'd1);
    tick();
    check_all("mis_done1", 0, 0, 0, 32'h0, 1, 1, 16'd1, 16'd1);
    tick();
    check_all("mis_done2", 0, 0, 0, 32'h0, 1, 1, 16'd1, 16'd1);
    recovery_done_ack = 1'b1;
    tick();
    check_all("mis_acked", 0, 0, 0, 32'h0, 0, 0, 16'd1, 16'd1);
    recovery_done_ack = 1'b0;
    redirect_ready = 1'b0;
    vp_lock = 1'b0;
    tick();
    check_all("mis_idle", 0, 0, 0, 32'h0, 0, 0, 16'd1, 16'd1);

    // Speculation cap: 10 issues, stall from the 8th onwards
    $display("[TB] speculation cap");
    vp_lock = 1'b1;
    tick();
    check_all("cap_spec", 0, 0, 0, 32'h0, 0, 1, 16'd1, 16'd1);
    issue_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_output($sformatf("cap_stall_after%0d", i), 32'(stall_fetch), (i >= 8) ? 32'd1 : 32'd0);
    end
    issue_valid = 1'b0;
    tick();
    check_output("cap_stall_held", 32'(stall_fetch), 32'd1);
    vp_done = 1'b1;
    tick();
    check_all("cap_done", 0, 0, 0, 32'h0, 0, 0, 16'd2, 16'd1);
    vp_done = 1'b0;
    vp_lock = 1'b0;
    tick();

    // Simultaneous en_recover + vp_done, then en_recover held past ack
    $display("[TB] simultaneous events");
    last_predicted_pc = 32'h0000_3000;
    redirect_ready = 1'b1;
    vp_lock = 1'b1;
    tick();
    en_recover = 1'b1;
    vp_done = 1'b1;
    tick();
    check_all("sim_flush1", 1, 1, 0, 32'h0, 0, 1, 16'd2, 16'd2);
    vp_done = 1'b0;
    tick();
    tick();
    check_all("sim_flush3", 1, 1, 0, 32'h0, 0, 1, 16'd2, 16'd2);
    tick();
    check_all("sim_redirect", 0, 1, 1, 32'h0000_3004, 0, 1, 16'd2, 16'd2);
    tick();
    check_all("sim_done", 0, 0, 0, 32'h0, 1, 1, 16'd2, 16'd2);
    recovery_done_ack = 1'b1;
    tick();
    recovery_done_ack = 1'b0;
    redirect_ready = 1'b0;
    vp_lock = 1'b0;
    check_all("sim_acked", 0, 0, 0, 32'h0, 0, 0, 16'd2, 16'd2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all($sformatf("held_no_retrigger%0d", i), 0, 0, 0, 32'h0, 0, 0, 16'd2, 16'd2);
    end

    // Re-arm, then wrap-around target with 5 cycles of backpressure
    $display("[TB] wrap and backpressure");
    en_recover = 1'b0;
    tick();
    check_all("rearm_idle", 0, 0, 0, 32'h0, 0, 0, 16'd2, 16'd2);
    last_predicted_pc = 32'hFFFF_FFFC;
    en_recover = 1'b1;
    tick();
    check_all("wrap_flush1", 1, 1, 0, 32'h0, 0, 1, 16'd2, 16'd3);
    en_recover = 1'b0;
    tick();
    tick();
    check_all("wrap_flush3", 1, 1, 0, 32'h0, 0, 1, 16'd2, 16'd3);
    tick();
    check_all("wrap_redirect1", 0, 1, 1, 32'h0000_0000, 0, 1, 16'd2, 16'd3);
    for (int i = 2; i <= 6; i++) begin
      tick();
      check_all($sformatf("wrap_redirect%0d", i), 0, 1, 1, 32'h0000_0000, 0, 1, 16'd2, 16'd3);
    end
    redirect_ready = 1'b1;
    tick();
    check_all("wrap_done", 0, 0, 0, 32'h0, 1, 1, 16'd2, 16'd3);
    redirect_ready = 1'b0;
    recovery_done_ack = 1'b1;
    tick();
    check_all("wrap_acked", 0, 0, 0, 32'h0, 0, 0, 16'd2, 16'd3);
    recovery_done_ack = 1'b0;

    // Reset asserted asynchronously in the middle of FLUSH
    $display("[TB] reset mid-flush");
    last_predicted_pc = 32'h0000_0500;
    vp_lock = 1'b1;
    tick();
    en_recover = 1'b1;
    tick();
    check_all("pre_reset_flush", 1, 1, 0, 32'h0, 0, 1, 16'd2, 16'd4);
    #2;
    rst = 1'b1;
    en_recover = 1'b0;
    vp_lock = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 32'h0, 0, 0, 16'd0, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    vp_lock = 1'b1;
    tick();
    check_all("post_reset_spec", 0, 0, 0, 32'h0, 0, 1, 16'd0, 16'd0);
    vp_done = 1'b1;
    tick();
    check_all("post_reset_correct", 0, 0, 0, 32'h0, 0, 0, 16'd1, 16'd0);
    vp_done = 1'b0;
    vp_lock = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
